// File: rtl/seq_player_multi.sv
// Step-table note sequencer: picks the next note on each choose pulse (forward, reverse,
// ping-pong or LFSR-random order), then hands it to the MIDI sender once it is not busy.
module seq_player_multi #(
    parameter int          STEPS     = 8,
    parameter int          BASE_NOTE = 60,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          IDX_W     = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pulse_choose_note,
    input  logic               busy,
    input  logic [1:0]         mode,
    input  logic [IDX_W:0]     len,
    input  logic signed [7:0]  transpose,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [7:0]         wr_data,
    output logic               pulse_send_note,
    output logic [7:0]         midi_note,
    output logic [IDX_W-1:0]   step_idx,
    output logic               overrun
);

    localparam logic [IDX_W:0] STEPS_L = (IDX_W+1)'(STEPS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               dir_up;
    logic [1:0]         mode_q;
    logic [15:0]        lfsr;
    logic [7:0]         notes [STEPS];

    logic [IDX_W:0]     len_eff;
    logic [IDX_W-1:0]   lm1;
    logic [IDX_W-1:0]   cur;
    logic [IDX_W-1:0]   rnd;
    logic [IDX_W-1:0]   nxt_idx;
    logic               dir_eff;
    logic               nxt_dir;
    logic [7:0]         entry;

    function automatic logic [IDX_W:0] eff_len(input logic [IDX_W:0] l);
        if (l == '0)
            return (IDX_W+1)'(1);
        if (l > STEPS_L)
            return STEPS_L;
        return l;
    endfunction

    function automatic logic [7:0] clamp_note(input logic [6:0] n, input logic signed [7:0] t);
        logic signed [8:0] sum;
        sum = $signed({2'b00, n}) + $signed({t[7], t});
        if (sum < 0)
            return 8'd0;
        if (sum > 9'sd127)
            return 8'd127;
        return {1'b0, sum[6:0]};
    endfunction

    always_comb begin
        len_eff = eff_len(len);
        lm1     = IDX_W'(len_eff - 1'b1);
        cur     = ({1'b0, idx} >= len_eff) ? '0 : idx;
        entry   = notes[cur];
        // A fresh entry into ping-pong always starts moving up.
        dir_eff = (mode_q == 2'd2) ? dir_up : 1'b1;
        nxt_dir = dir_eff;
        rnd     = lfsr[IDX_W-1:0];
        nxt_idx = '0;
        case (mode)
            2'd0: nxt_idx = (cur == lm1) ? '0 : cur + 1'b1;
            2'd1: nxt_idx = (cur == '0) ? lm1 : cur - 1'b1;
            2'd2: begin
                if (lm1 == '0) begin
                    nxt_idx = '0;
                end else if (dir_eff) begin
                    if (cur == lm1) begin
                        nxt_dir = 1'b0;
                        nxt_idx = cur - 1'b1;
                    end else begin
                        nxt_idx = cur + 1'b1;
                    end
                end else begin
                    if (cur == '0) begin
                        nxt_dir = 1'b1;
                        nxt_idx = cur + 1'b1;
                    end else begin
                        nxt_idx = cur - 1'b1;
                    end
                end
            end
            default: nxt_idx = ({1'b0, rnd} >= len_eff) ? '0 : rnd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            idx             <= '0;
            dir_up          <= 1'b1;
            mode_q          <= 2'd0;
            lfsr            <= LFSR_SEED;
            midi_note       <= 8'd0;
            step_idx        <= '0;
            pulse_send_note <= 1'b0;
            overrun         <= 1'b0;
            for (int i = 0; i < STEPS; i++)
                notes[i] <= 8'(BASE_NOTE + i);
        end else begin
            lfsr            <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            mode_q          <= mode;
            pulse_send_note <= 1'b0;
            overrun         <= 1'b0;
            if (mode == 2'd2 && mode_q != 2'd2)
                dir_up <= 1'b1;
            if (wr_en)
                notes[wr_addr] <= wr_data;
            case (state)
                S_IDLE: begin
                    if (pulse_choose_note) begin
                        step_idx <= cur;
                        idx      <= nxt_idx;
                        if (mode == 2'd2)
                            dir_up <= nxt_dir;
                        // Rest steps advance the index but leave the last note latched.
                        if (!entry[7]) begin
                            midi_note <= clamp_note(entry[6:0], transpose);
                            state     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    overrun <= pulse_choose_note;
                    if (!busy) begin
                        state           <= S_SEND;
                        pulse_send_note <= 1'b1;
                    end
                end
                S_SEND: begin
                    overrun <= pulse_choose_note;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_player_multi.sv
// Directed and randomized checks of seq_player_multi against a step-order / clamp model.
module tb_seq_player_multi;

    localparam int          STEPS = 8;
    localparam int          IDX_W = 3;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               pulse_choose_note = 1'b0;
    logic               busy = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic [IDX_W:0]     len = 4'd8;
    logic signed [7:0]  transpose = 8'sd0;
    logic               wr_en = 1'b0;
    logic [IDX_W-1:0]   wr_addr = '0;
    logic [7:0]         wr_data = 8'd0;
    logic               pulse_send_note;
    logic [7:0]         midi_note;
    logic [IDX_W-1:0]   step_idx;
    logic               overrun;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mtab [STEPS];
    logic [15:0] m_lfsr;
    logic [15:0] lfsr_at;

    seq_player_multi #(.STEPS(STEPS), .BASE_NOTE(60), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .pulse_choose_note(pulse_choose_note), .busy(busy),
        .mode(mode), .len(len), .transpose(transpose), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pulse_send_note(pulse_send_note), .midi_note(midi_note),
        .step_idx(step_idx), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Reference random source: 16-bit Fibonacci LFSR, taps 16,14,13,11.
    always @(posedge clk) begin
        if (!rst)
            m_lfsr <= SEED;
        else
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp(input int n, input int t);
        int s;
        s = (n & 127) + t;
        if (s < 0) return 0;
        if (s > 127) return 127;
        return s;
    endfunction

    function automatic int pingpong(input int k, input int l);
        int p;
        if (l == 1) return 0;
        p = k % (2 * (l - 1));
        return (p < l) ? p : 2 * (l - 1) - p;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        pulse_choose_note = 1'b0;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < STEPS; i++) mtab[i] = 60 + i;
    endtask

    task automatic wr(input int addr, input int data);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = IDX_W'(addr);
        wr_data = 8'(data);
        @(negedge clk);
        wr_en = 1'b0;
        mtab[addr] = data;
    endtask

    task automatic pulse_choose();
        @(negedge clk);
        pulse_choose_note = 1'b1;
        lfsr_at = m_lfsr;
        @(negedge clk);
        pulse_choose_note = 1'b0;
    endtask

    // One choose with busy low; ten cycles from choose to the next one.
    task automatic play(input string tag, input int exp_idx, input int exp_note, input bit exp_send);
        pulse_choose();
        check({tag, "_idx"}, 32'(step_idx), exp_idx);
        check({tag, "_note"}, 32'(midi_note), exp_note);
        check({tag, "_early"}, 32'(pulse_send_note), 0);
        check({tag, "_ovr"}, 32'(overrun), 0);
        @(negedge clk);
        check({tag, "_send"}, 32'(pulse_send_note), 32'(exp_send));
        @(negedge clk);
        check({tag, "_one"}, 32'(pulse_send_note), 0);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int l_eff, cur, nxt, last_note, tr_i, en, addr, data;
        int seq1 [50];
        int gaps [50];

        // Forward, len 8, plus reset state.
        mode = 2'd0; len = 4'd8; transpose = 8'sd0; busy = 1'b0;
        do_reset();
        check("rst_note", 32'(midi_note), 0);
        check("rst_idx", 32'(step_idx), 0);
        check("rst_send", 32'(pulse_send_note), 0);
        check("rst_ovr", 32'(overrun), 0);
        for (int k = 0; k < 10; k++)
            play($sformatf("fwd%0d", k), k % 8, 60 + (k % 8), 1'b1);

        // Ping-pong, len 4.
        mode = 2'd2; len = 4'd4;
        do_reset();
        for (int k = 0; k < 8; k++)
            play($sformatf("pp%0d", k), pingpong(k, 4), 60 + pingpong(k, 4), 1'b1);

        // Reverse, len 3.
        mode = 2'd1; len = 4'd3;
        do_reset();
        for (int k = 0; k < 4; k++)
            play($sformatf("rev%0d", k), (3 - (k % 3)) % 3, 60 + (3 - (k % 3)) % 3, 1'b1);

        // Busy hold with a dropped choose.
        mode = 2'd0; len = 4'd8;
        do_reset();
        busy = 1'b1;
        pulse_choose();
        check("busy_idx", 32'(step_idx), 0);
        check("busy_note", 32'(midi_note), 60);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("busy_hold%0d", c), 32'(pulse_send_note), 0);
            if (c == 5) pulse_choose_note = 1'b1;
            if (c == 6) begin
                pulse_choose_note = 1'b0;
                check("ovr_pulse", 32'(overrun), 1);
                check("ovr_idx", 32'(step_idx), 0);
            end
            if (c == 7) check("ovr_one", 32'(overrun), 0);
        end
        busy = 1'b0;
        @(negedge clk);
        check("busy_release", 32'(pulse_send_note), 1);
        @(negedge clk);
        check("busy_release_one", 32'(pulse_send_note), 0);
        repeat (4) @(negedge clk);
        play("after_ovr", 1, 61, 1'b1);

        // Rest step and transpose clamping.
        do_reset();
        wr(2, 8'h80);
        play("rest0", 0, 60, 1'b1);
        play("rest1", 1, 61, 1'b1);
        play("rest2", 2, 61, 1'b0);
        wr(5, 120);
        transpose = 8'sd20;
        play("tp3", 3, 83, 1'b1);
        play("tp4", 4, 84, 1'b1);
        play("clamp_hi", 5, 127, 1'b1);
        wr(0, 3);
        transpose = 8'shF6;
        play("tn6", 6, 56, 1'b1);
        play("tn7", 7, 57, 1'b1);
        play("clamp_lo", 0, 0, 1'b1);
        // Write and choose of entry 1 at the same edge: old data plays.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'd100;
        pulse_choose_note = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; pulse_choose_note = 1'b0;
        mtab[1] = 100;
        check("same_edge_idx", 32'(step_idx), 1);
        check("same_edge_note", 32'(midi_note), clamp(61, -10));
        repeat (8) @(negedge clk);
        play("rest_again", 2, clamp(61, -10), 1'b0);
        transpose = 8'sd0;

        // Random order, len 5, then replay after reset with identical timing.
        mode = 2'd3; len = 4'd5;
        do_reset();
        cur = 0;
        for (int k = 0; k < 50; k++) begin
            gaps[k] = $urandom_range(0, 4);
            repeat (gaps[k]) @(negedge clk);
            play($sformatf("rnd%0d", k), cur, 60 + cur, 1'b1);
            seq1[k] = int'(step_idx);
            check($sformatf("rnd_range%0d", k), 32'(step_idx < 3'd5), 1);
            nxt = int'(lfsr_at) & (STEPS - 1);
            cur = (nxt >= 5) ? 0 : nxt;
        end
        do_reset();
        for (int k = 0; k < 50; k++) begin
            repeat (gaps[k]) @(negedge clk);
            pulse_choose();
            check($sformatf("rnd_rep%0d", k), 32'(step_idx), seq1[k]);
            repeat (8) @(negedge clk);
        end

        // Forward play with random len, table contents and transpose.
        mode = 2'd0;
        len = 4'($urandom_range(0, 15));
        l_eff = (len == 0) ? 1 : (int'(len) > STEPS ? STEPS : int'(len));
        do_reset();
        last_note = 0;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                addr = $urandom_range(0, STEPS - 1);
                data = (($urandom_range(0, 3) == 0) ? 128 : 0) + $urandom_range(0, 127);
                wr(addr, data);
            end
            tr_i = $urandom_range(0, 255) - 128;
            transpose = 8'(tr_i);
            cur = k % l_eff;
            if (mtab[cur] >= 128) begin
                play($sformatf("rfw%0d", k), cur, last_note, 1'b0);
            end else begin
                en = clamp(mtab[cur], tr_i);
                last_note = en;
                play($sformatf("rfw%0d", k), cur, en, 1'b1);
            end
        end
        transpose = 8'sd0;

        // Reset while waiting on busy.
        len = 4'd8;
        do_reset();
        busy = 1'b1;
        pulse_choose();
        check("wait_note", 32'(midi_note), 60);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        busy = 1'b0;
        for (int i = 0; i < STEPS; i++) mtab[i] = 60 + i;
        check("abort_note", 32'(midi_note), 0);
        check("abort_idx", 32'(step_idx), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("abort_nosend%0d", c), 32'(pulse_send_note), 0);
        end
        play("post_abort", 0, 60, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_player_multi.md
Name: seq_player_multi

Overview:
Parametrised successor to the single-pattern note sequencer. It holds a writable step table of STEPS notes with a programmable active length, four playback modes (forward, reverse, ping-pong, LFSR random), rest steps and clamped transpose. Each pulse_choose_note selects the next note. The block then issues one pulse_send_note to the downstream MIDI transmitter once that transmitter deasserts busy. It sits between the tempo/pulse generator and the MIDI UART sender.

Parameters:
STEPS, 8, number of step-table entries (power of two, 2..64); IDX_W = log2(STEPS).
BASE_NOTE, 60, reset content: entry i = BASE_NOTE + i.
LFSR_SEED, 16'hACE1, reset value of the 16-bit random LFSR (must be nonzero).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-low reset.
pulse_choose_note  in  1  one-cycle request to choose and play the next step.
busy  in  1  downstream sender busy; no send while high.
mode  in  2  0 forward, 1 reverse, 2 ping-pong, 3 random.
len  in  IDX_W+1  active step count; 0 is treated as 1; values above STEPS are treated as STEPS.
transpose  in  8  signed semitone offset.
wr_en  in  1  table write strobe.
wr_addr  in  IDX_W  table write address.
wr_data  in  8  bit7 = rest flag, bits6:0 = note.
pulse_send_note  out  1  one-cycle strobe: midi_note is valid for sending.
midi_note  out  8  chosen note; bit7 is always 0.
step_idx  out  IDX_W  index of the most recently chosen step.
overrun  out  1  one-cycle strobe: a choose request was dropped.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - state = IDLE, idx = 0, pingpong dir = up, LFSR = LFSR_SEED.
  - midi_note = 0, step_idx = 0, pulse_send_note = 0, overrun = 0.
  - Table reloaded to BASE_NOTE + i, rest flags clear.
  - Reset mid-operation abandons any pending note; no send follows.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It steps every cycle while out of reset.
- FSM:
  - IDLE + pulse_choose_note, current entry not rest: midi_note = clamp(entry[6:0] + transpose) to 0..127. step_idx = idx. Index advances. Next state WAIT. midi_note holds until the next non-rest choose.
  - IDLE + pulse_choose_note, entry is rest: step_idx updates, index advances, state stays IDLE. No send; midi_note unchanged.
  - WAIT: busy == 0 at the edge -> SEND; otherwise stay in WAIT (unbounded).
  - SEND: pulse_send_note = 1 for exactly this one cycle, then IDLE.
  - Minimum latency: choose sampled at edge k; pulse_send_note high in the cycle after edge k+1.
- Choose requests in WAIT or SEND are dropped. overrun = 1 in the cycle after the dropped request. idx is unchanged.
- Index rules. Let L = effective len. If idx >= L when a choose arrives, play step 0 and advance from 0.
  - Forward: next = (idx == L-1) ? 0 : idx+1.
  - Reverse: next = (idx == 0) ? L-1 : idx-1.
  - Ping-pong: endpoints are not repeated (L=4: 0,1,2,3,2,1,0,1...). The direction flips on reaching 0 or L-1. L == 1 gives always 0.
  - Random: next = LFSR[IDX_W-1:0]; if that value is >= L, next = 0.
  - A mode change applies at the next advance. Ping-pong dir resets to up when entering mode 2.
- Table write: takes effect at the edge. A write and a choose of the same entry at the same edge reads the old data. Writes never alter an already-latched midi_note.
- Transpose arithmetic: 9-bit signed sum. Sum < 0 -> 0; sum > 127 -> 127.

Test Plan:
- Reset, mode 0, len 8, transpose 0, busy 0; 10 chooses spaced 10 cycles -> midi_note 60,61,...,67,60,61. Each pulse_send_note is one cycle, two edges after its choose.
- Mode 2, len 4 -> step_idx 0,1,2,3,2,1,0,1. Mode 1, len 3 from reset -> 0,2,1,0.
- busy held high 20 cycles after a choose -> no pulse_send_note until one cycle after busy falls. A second choose during the wait -> overrun pulse, idx unchanged.
- Write entry 2 = 8'h80 (rest); forward play -> no send on step 2, step_idx = 2, midi_note keeps the step-1 value. Entry 5 = 120 with transpose +20 -> 127. Entry 0 = 3 with transpose -10 (8'hF6) -> 0.
- Mode 3, len 5, 50 chooses -> every step_idx < 5; sequence repeats identically after reset with the same seed.
- Pull rst low while in WAIT -> no pulse_send_note; midi_note = 0; the next choose plays entry 0 = 60.
